// File: rtl/nor_4b_checker.sv
// Response checker for the nor_4b stimulus stream: registers each accepted triple, compares
// against ~(x | y) one cycle later, counts vectors/mismatches and latches the first failure.
// Optional NOR_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module nor_4b_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_x,
  output logic [WIDTH-1:0] err_y,
  output logic [WIDTH-1:0] err_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             s1_valid_q, s1_last_q;
  logic [WIDTH-1:0] s1_x_q, s1_y_q, s1_out_q, s1_exp_q;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [WIDTH-1:0] err_x_q, err_x_d, err_y_q, err_y_d, err_out_q, err_out_d;

  logic mismatch, stop_det, accept, start_ok;

  assign mismatch = s1_valid_q && (s1_exp_q != s1_out_q);

`ifdef NOR_CHK_STOP_ON_FAIL_EN
  assign stop_det = mismatch && !err_valid_q;
`else
  assign stop_det = 1'b0;
`endif

  // Detection blocks the same-cycle accept, so nothing beyond the failing vector is counted.
  assign in_ready = (state_q == StRun) && !stop_det;
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (stop_det)                state_d = StDone;
        else if (accept && in_last)  state_d = StDrain;
      end
      StDrain: if (stop_det || (s1_valid_q && s1_last_q)) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    err_x_d     = err_x_q;
    err_y_d     = err_y_q;
    err_out_d   = err_out_q;
    if (start_ok) begin
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      err_valid_d = 1'b0;
      err_x_d     = '0;
      err_y_d     = '0;
      err_out_d   = '0;
    end else if (s1_valid_q) begin
      if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + 1'b1;
      if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      if (mismatch && !err_valid_q) begin
        err_valid_d = 1'b1;
        err_x_d     = s1_x_q;
        err_y_d     = s1_y_q;
        err_out_d   = s1_out_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_out_q    <= '0;
      s1_exp_q    <= '0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_x_q     <= '0;
      err_y_q     <= '0;
      err_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_x_q    <= x;
        s1_y_q    <= y;
        s1_out_q  <= dut_out;
        s1_exp_q  <= ~(x | y);
      end
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      err_x_q     <= err_x_d;
      err_y_q     <= err_y_d;
      err_out_q   <= err_out_d;
    end
  end

  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_cnt_q == '0);
  assign vec_cnt   = vec_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_valid = err_valid_q;
  assign err_x     = err_x_q;
  assign err_y     = err_y_q;
  assign err_out   = err_out_q;

endmodule

// File: tb/tb_nor_4b_checker.sv
// Scoreboard bench for nor_4b_checker: per-vector counter expectations and per-run verdicts
// are queued by the stimulus and checked by an independent monitor.
module tb_nor_4b_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  x = '0, y = '0, dut_out = '0;
  logic        busy, done, pass, err_valid;
  logic [15:0] vec_cnt, err_cnt;
  logic [3:0]  err_x, err_y, err_out;

  nor_4b_checker #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .x(x), .y(y), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt), .err_valid(err_valid),
    .err_x(err_x), .err_y(err_y), .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       vec;
    int       err;
    bit       pass;
    bit       ev;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [3:0] eo;
  } run_t;
  typedef struct {
    int vec;
    int err;
  } cnt_t;

  run_t run_q[$];
  cnt_t vec_q[$];
  int   total = 0;
  int   passed = 0;
  int   m_vec = 0;
  int   m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_vec = 0;
    m_err = 0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                      input bit last, input bit bad);
    int n = 0;
    x = a; y = b; dut_out = o; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    m_vec++;
    if (bad) m_err++;
    vec_q.push_back('{m_vec, m_err});
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      $display("FAIL done_timeout: done stayed 0, expected 1 within 10 cycles");
    end
  endtask

  // Monitor: counters are compared two falling edges after an accept is seen,
  // i.e. just after the edge that follows the accepting edge.
  initial begin : monitor
    bit acc1 = 0, acc2 = 0, done_prev = 0;
    cnt_t c;
    run_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc1 = 0; acc2 = 0; done_prev = 0;
      end else begin
        if (acc2) begin
          if (vec_q.size() == 0) begin
            total++;
            $display("FAIL sb_vec_underflow: counter update with no expectation queued");
          end else begin
            c = vec_q.pop_front();
            check("sb_vec_cnt", {16'd0, vec_cnt}, c.vec);
            check("sb_err_cnt", {16'd0, err_cnt}, c.err);
          end
        end
        if (done && !done_prev) begin
          if (run_q.size() == 0) begin
            total++;
            $display("FAIL sb_run_underflow: done with no run expectation queued");
          end else begin
            r = run_q.pop_front();
            check("run_vec_cnt", {16'd0, vec_cnt}, r.vec);
            check("run_err_cnt", {16'd0, err_cnt}, r.err);
            check("run_pass", {31'd0, pass}, {31'd0, r.pass});
            check("run_err_valid", {31'd0, err_valid}, {31'd0, r.ev});
            check("run_err_x", {28'd0, err_x}, {28'd0, r.ex});
            check("run_err_y", {28'd0, err_y}, {28'd0, r.ey});
            check("run_err_out", {28'd0, err_out}, {28'd0, r.eo});
          end
        end
        done_prev = done;
        acc2 = acc1;
        acc1 = in_valid && in_ready;
      end
    end
  end

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_vec_cnt", {16'd0, vec_cnt}, 0);
    check("rst_err_cnt", {16'd0, err_cnt}, 0);
    check("rst_err_valid", {31'd0, err_valid}, 0);
    check("rst_err_x", {28'd0, err_x}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Run A: all four vectors correct
    run_q.push_back('{4, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0});
    do_start();
    @(negedge clk);
    check("a_in_ready_run", {31'd0, in_ready}, 1);
    check("a_busy_run", {31'd0, busy}, 1);
    step();
    send(4'b1000, 4'b0000, 4'b0111, 1'b0, 1'b0);
    send(4'b1000, 4'b1001, 4'b0110, 1'b0, 1'b0);
    send(4'b1101, 4'b1001, 4'b0010, 1'b0, 1'b0);
    send(4'b1101, 4'b0110, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    check("a_ready_drop", {31'd0, in_ready}, 0);
    check("a_drain_not_done", {31'd0, done}, 0);
    check("a_drain_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check("a_done_latency", {31'd0, done}, 1);
    check("a_pass", {31'd0, pass}, 1);
    step();

    // Run B: started from DONE, two mismatches, start pulse in RUN ignored
    run_q.push_back('{4, 2, 1'b0, 1'b1, 4'b1000, 4'b1001, 4'b0111});
    do_start();
    check("b_clear_vec", {16'd0, vec_cnt}, 0);
    check("b_clear_done", {31'd0, done}, 0);
    check("b_restart_busy", {31'd0, busy}, 1);
    send(4'b1000, 4'b0000, 4'b0111, 1'b0, 1'b0);
    send(4'b1000, 4'b1001, 4'b0111, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("b_start_ignored_vec", {16'd0, vec_cnt}, 2);
    check("b_start_ignored_err", {16'd0, err_cnt}, 1);
    check("b_start_ignored_ev", {31'd0, err_valid}, 1);
    step();
    send(4'b1101, 4'b1001, 4'b0010, 1'b0, 1'b0);
    send(4'b1101, 4'b0110, 4'b0001, 1'b1, 1'b1);
    wait_done();
    check("b_fail_verdict", {31'd0, pass}, 0);
    step();

    // Run C: single-vector run; later in_valid pulses must not be accepted
    run_q.push_back('{1, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0});
    do_start();
    check("c_clear_err_valid", {31'd0, err_valid}, 0);
    send(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 0);
      x = 4'b0101; y = 4'b0011; dut_out = 4'b1000;
      @(negedge clk);
      check("c_ready_low", {31'd0, in_ready}, 0);
      step();
    end
    in_valid = 1'b0;
    check("c_vec_single", {16'd0, vec_cnt}, 1);

    // Run D: reset in the middle of a run, then a fresh run
    do_start();
    send(4'b0001, 4'b0010, 4'b1100, 1'b0, 1'b0);
    send(4'b0100, 4'b0100, 4'b1011, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("d_rst_busy", {31'd0, busy}, 0);
    check("d_rst_vec", {16'd0, vec_cnt}, 0);
    check("d_rst_in_ready", {31'd0, in_ready}, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("d_idle_busy", {31'd0, busy}, 0);
    check("d_idle_done", {31'd0, done}, 0);
    step();
    run_q.push_back('{1, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0});
    do_start();
    check("d_fresh_vec", {16'd0, vec_cnt}, 0);
    send(4'b1010, 4'b0100, 4'b0001, 1'b1, 1'b0);
    wait_done();

    repeat (3) step();
    check("sb_run_drained", run_q.size(), 0);
    check("sb_vec_drained", vec_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nor_4b_checker.md
Name: nor_4b_checker

Overview:
- Synthesizable response checker at the receiving end of the nor_4b stimulus stream.
- Accepts (x, y, dut_out) triples over a valid/ready handshake and computes the expected NOR.
- Compares each triple, counts vectors and mismatches, and latches the first failing triple.
- Sits beside nor_4b so on-chip or bench stimulus gets a registered pass/fail verdict instead of $monitor inspection.

Parameters:
- WIDTH, 4, operand/result width in bits.
- CNT_W, 16, width of vector and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears counters/capture and begins a run.
- in_valid  input  1  triple on x/y/dut_out is valid.
- in_ready  output  1  checker can accept a triple this cycle.
- in_last  input  1  qualifies the accepted triple as the final one of the run.
- x  input  WIDTH  stimulus operand A.
- y  input  WIDTH  stimulus operand B.
- dut_out  input  WIDTH  DUT response for (x, y).
- busy  output  1  run in progress (RUN or DRAIN).
- done  output  1  run complete; held until next start.
- pass  output  1  valid when done; 1 iff err_cnt == 0.
- vec_cnt  output  CNT_W  accepted vectors this run.
- err_cnt  output  CNT_W  mismatching vectors this run.
- err_valid  output  1  sticky; first-mismatch capture holds data.
- err_x, err_y, err_out  output  WIDTH each  captured first failing triple.

Behaviour:
- Reset: async on rst_n low. State = IDLE. All outputs and counters = 0, including in_ready, done, pass, err_valid and err_x/err_y/err_out.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- DONE -> RUN on start; counters, done, pass and err_* clear in the same edge.
- start in RUN or DRAIN is ignored.
- in_ready = 1 only in RUN. Accept = in_valid && in_ready. x/y/dut_out/in_last are don't-care when not accepted.
- Stage 1, at the accept edge:
  - register x, y, dut_out and in_last;
  - compute exp = ~(x | y), all WIDTH bits;
  - set s1_valid.
- Stage 2, one cycle after accept:
  - vec_cnt += 1;
  - if exp != dut_out: err_cnt += 1;
  - if exp != dut_out and err_valid == 0: capture the triple and set err_valid.
- Counter latency: counters update exactly 1 cycle after the accepting edge.
- Throughput: one vector per cycle, back-to-back.
- Saturation: both counters saturate at all-ones and never wrap; err_cnt <= vec_cnt always.
- RUN -> DRAIN when the accepted triple has in_last = 1; in_ready drops the next cycle.
- DRAIN -> DONE once stage 2 has processed the last vector, i.e. 1 cycle in DRAIN.
- done and pass are valid in the same cycle that the final counts are visible.
- In DONE:
  - done = 1 and pass = (err_cnt == 0);
  - both hold until the next start.
- pass = 0 in every state other than DONE.
- Reset mid-run: immediate return to IDLE, all state lost; no partial verdict.
- in_last on the very first vector gives a single-vector run: vec_cnt = 1, DONE 2 cycles after the accept.

Optional Feature:
- Macro: NOR_CHK_STOP_ON_FAIL_EN.
- Defined: on the cycle stage 2 detects the first mismatch:
  - in_ready drops immediately and no further triples are accepted;
  - the FSM goes to DONE on the next edge with pass = 0;
  - a triple accepted in the same cycle as the detection is discarded and not counted.
- Undefined: the run always continues to in_last and all mismatches are counted.

Test Plan:
- Reset then start; stream 4 triples (1000,0000,0111), (1000,1001,0110), (1101,1001,0010), (1101,0110,0000); last flagged on the 4th -> done = 1 and pass = 1 two cycles after the last accept; vec_cnt = 4, err_cnt = 0, err_valid = 0.
- Same stream with the 2nd dut_out = 0111 and 4th = 0001 -> err_cnt = 2, pass = 0, err_valid = 1, err_x = 1000, err_y = 1001, err_out = 0111 (first failure only).
- in_valid toggling 1,0,1,1 with a single in_last vector at the start -> in_ready = 1 only in RUN; vec_cnt counts accepted triples only; in_ready = 0 one cycle after the last accept.
- Drive rst_n low for 1 cycle while in RUN after 2 vectors -> all outputs 0 and state IDLE; a new start gives a fresh run with vec_cnt starting at 0.
- start pulsed in RUN -> ignored. start in DONE -> counters and err_* cleared and RUN entered on the same edge.
- With NOR_CHK_STOP_ON_FAIL_EN: mismatch on vector 2 of 4 -> in_ready = 0 in the detect cycle; DONE next edge, vec_cnt = 2, err_cnt = 1, pass = 0.
